// File: rtl/ring_flit_serializer.sv
// Transmit-side ring serializer: parallel-loads one message and emits it one flit per cycle.
// Optional even-parity output on flit_par is enabled by defining FLIT_SER_PARITY_EN.
module ring_flit_serializer #(
  parameter int DEPTH     = 11,
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DEPTH*WIDTH-1:0] din,
  input  logic                   flush,
  output logic [WIDTH-1:0]       flit_out,
  output logic                   flit_valid,
  input  logic                   flit_ready,
  output logic                   flit_head,
  output logic                   flit_tail,
  output logic                   busy
`ifdef FLIT_SER_PARITY_EN
  ,
  output logic                   flit_par
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  // Header length field: zero still sends the header word, oversize clamps to buffer depth.
  function automatic logic [CNT_WIDTH-1:0] eff_len(input logic [CNT_WIDTH-1:0] l);
    if (l == '0)
      return ONE_C;
    else if (l > DEPTH_C)
      return DEPTH_C;
    else
      return l;
  endfunction

`ifdef FLIT_SER_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  state_t               state;
  logic [WIDTH-1:0]     msg_buf [DEPTH];
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] len;
  logic [CNT_WIDTH-1:0] idx_nxt;
  logic [CNT_WIDTH-1:0] len_in;
  logic [WIDTH-1:0]     word_nxt;

  assign idx_nxt  = idx + ONE_C;
  assign len_in   = eff_len(din[CNT_WIDTH-1:0]);
  // Only consumed on a non-tail transfer, where idx_nxt <= len-1 < DEPTH.
  assign word_nxt = msg_buf[idx_nxt];

  // Single state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      len        <= '0;
      for (int i = 0; i < DEPTH; i++)
        msg_buf[i] <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      flit_valid <= 1'b0;
      flit_out   <= '0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
`ifdef FLIT_SER_PARITY_EN
      flit_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            for (int i = 0; i < DEPTH; i++)
              msg_buf[i] <= din[i*WIDTH +: WIDTH];
            len        <= len_in;
            idx        <= '0;
            state      <= SEND;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            flit_valid <= 1'b1;
            flit_out   <= din[WIDTH-1:0];
            flit_head  <= 1'b1;
            flit_tail  <= (len_in == ONE_C);
`ifdef FLIT_SER_PARITY_EN
            flit_par   <= even_par(din[WIDTH-1:0]);
`endif
          end
        end
        SEND: begin
          // A flit transferring in the flush cycle is sent, but the message stops there.
          if (flush || (flit_ready && flit_tail)) begin
            state      <= IDLE;
            idx        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            flit_valid <= 1'b0;
            flit_out   <= '0;
            flit_head  <= 1'b0;
            flit_tail  <= 1'b0;
`ifdef FLIT_SER_PARITY_EN
            flit_par   <= 1'b0;
`endif
          end else if (flit_ready) begin
            idx        <= idx_nxt;
            flit_out   <= word_nxt;
            flit_head  <= 1'b0;
            flit_tail  <= (idx_nxt == (len - ONE_C));
`ifdef FLIT_SER_PARITY_EN
            flit_par   <= even_par(word_nxt);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
